// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron array: FSM states, default threshold, leak field width.
`default_nettype none

package lif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lif_state_e;

    localparam int unsigned THR_DEFAULT = 32'h0000_00E6;
    localparam int          LEAK_W      = 3;

endpackage

`default_nettype wire

// File: rtl/lif_core.sv
// Combinational single-channel LIF update: leak, saturating integrate, threshold, reset mode, refractory.
`default_nettype none

module lif_core
    import lif_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RW    = 3
) (
    input  logic [WIDTH-1:0]  u_i,
    input  logic [WIDTH-1:0]  cur_i,
    input  logic [RW-1:0]     r_i,
    input  logic [WIDTH-1:0]  thr_i,
    input  logic [LEAK_W-1:0] leak_i,
    input  logic              sub_i,
    input  logic [RW-1:0]     refrac_i,
    output logic [WIDTH-1:0]  u_o,
    output logic [RW-1:0]     r_o,
    output logic              spike_o
);

    logic [WIDTH-1:0] decay;
    logic [WIDTH-1:0] cur_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat;
    logic             refractory;

    assign refractory = (r_i != '0);

    // A zero shift would otherwise subtract the whole potential.
    assign decay   = (leak_i == '0) ? u_i : (u_i - (u_i >> leak_i));
    assign cur_eff = refractory ? '0 : cur_i;
    assign sum     = {1'b0, decay} + {1'b0, cur_eff};
    assign sat     = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

    assign spike_o = !refractory && (sat >= thr_i);

    always_comb begin
        u_o = sat;
        r_o = '0;
        if (refractory) begin
            r_o = r_i - RW'(1);
        end else if (spike_o) begin
            u_o = sub_i ? (sat - thr_i) : '0;
            r_o = refrac_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lif_neuron_array.sv
// Array of N_CH leaky integrate-and-fire neurons sharing one time-multiplexed lif_core,
// one channel per cycle per time step.
`default_nettype none

module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter int          N_CH    = 4,
    parameter int          RW      = 3,
    parameter int unsigned THR_RST = THR_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_valid,
    output logic                    step_ready,
    input  logic [N_CH*WIDTH-1:0]   current,
    input  logic                    cfg_we,
    input  logic [WIDTH-1:0]        cfg_thr,
    input  logic [LEAK_W-1:0]       cfg_leak,
    input  logic                    cfg_sub,
    input  logic [RW-1:0]           cfg_refrac,
    output logic                    out_valid,
    output logic [N_CH-1:0]         spike,
    output logic [N_CH*WIDTH-1:0]   state
);

    localparam int             IW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_CH - 1);

    lif_state_e                   fsm_q;
    logic [IW-1:0]                idx_q;
    logic                         out_valid_q;

    logic [N_CH-1:0][WIDTH-1:0]   cur_q;
    logic [N_CH-1:0][WIDTH-1:0]   u_q;
    logic [N_CH-1:0][RW-1:0]      r_q;
    logic [N_CH-1:0]              spike_q;

    logic [WIDTH-1:0]             thr_q;
    logic [LEAK_W-1:0]            leak_q;
    logic                         sub_q;
    logic [RW-1:0]                refrac_q;

    logic [WIDTH-1:0]             u_d;
    logic [RW-1:0]                r_d;
    logic                         spike_d;
    logic                         idle;
    logic                         accept;

    assign idle       = (fsm_q == IDLE);
    assign accept     = idle && step_valid;
    assign step_ready = idle;
    assign out_valid  = out_valid_q;
    assign spike      = spike_q;
    assign state      = u_q;

    lif_core #(
        .WIDTH (WIDTH),
        .RW    (RW)
    ) u_core (
        .u_i      (u_q[idx_q]),
        .cur_i    (cur_q[idx_q]),
        .r_i      (r_q[idx_q]),
        .thr_i    (thr_q),
        .leak_i   (leak_q),
        .sub_i    (sub_q),
        .refrac_i (refrac_q),
        .u_o      (u_d),
        .r_o      (r_d),
        .spike_o  (spike_d)
    );

    // out_valid is registered off DONE, so the pulse lands N_CH+1 cycles after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (step_valid) begin
                        fsm_q <= UPDATE;
                        idx_q <= '0;
                    end
                end
                UPDATE: begin
                    if (idx_q == LAST_IDX) begin
                        fsm_q <= DONE;
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    fsm_q       <= IDLE;
                    out_valid_q <= 1'b1;
                end
                default: begin
                    fsm_q <= IDLE;
                    idx_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q    <= WIDTH'(THR_RST);
            leak_q   <= '0;
            sub_q    <= 1'b0;
            refrac_q <= '0;
        end else if (cfg_we && idle) begin
            thr_q    <= cfg_thr;
            leak_q   <= cfg_leak;
            sub_q    <= cfg_sub;
            refrac_q <= cfg_refrac;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            u_q     <= '0;
            r_q     <= '0;
            spike_q <= '0;
        end else if (accept) begin
            cur_q   <= current;
            spike_q <= '0;
        end else if (fsm_q == UPDATE) begin
            u_q[idx_q]     <= u_d;
            r_q[idx_q]     <= r_d;
            spike_q[idx_q] <= spike_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios plus randomized steps against a reference model.
`default_nettype none

module tb_lif_neuron_array;

    localparam int N  = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            step_valid;
    logic            step_ready;
    logic [N*W-1:0]  current;
    logic            cfg_we;
    logic [W-1:0]    cfg_thr;
    logic [2:0]      cfg_leak;
    logic            cfg_sub;
    logic [2:0]      cfg_refrac;
    logic            out_valid;
    logic [N-1:0]    spike;
    logic [N*W-1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    int m_u [N];
    int m_r [N];
    int m_spk [N];
    int m_thr, m_leak, m_sub, m_refrac;

    always #5 clk = ~clk;

    lif_neuron_array #(.WIDTH(W), .N_CH(N), .RW(3), .THR_RST(32'hE6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .current    (current),
        .cfg_we     (cfg_we),
        .cfg_thr    (cfg_thr),
        .cfg_leak   (cfg_leak),
        .cfg_sub    (cfg_sub),
        .cfg_refrac (cfg_refrac),
        .out_valid  (out_valid),
        .spike      (spike),
        .state      (state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_u[k] = 0; m_r[k] = 0; m_spk[k] = 0;
        end
        m_thr = 'hE6; m_leak = 0; m_sub = 0; m_refrac = 0;
    endtask

    // One time step of the neuron rules on plain integers.
    task automatic model_step(input logic [N*W-1:0] cur);
        int u, i, d, s;
        for (int k = 0; k < N; k++) begin
            u = m_u[k];
            i = int'(cur[k*W +: W]);
            d = (m_leak == 0) ? u : u - (u >> m_leak);
            m_spk[k] = 0;
            if (m_r[k] > 0) begin
                m_u[k] = d;
                m_r[k] = m_r[k] - 1;
            end else begin
                s = d + i;
                if (s > 255) s = 255;
                if (s >= m_thr) begin
                    m_spk[k] = 1;
                    m_u[k]   = m_sub ? (s - m_thr) : 0;
                    m_r[k]   = m_refrac;
                end else begin
                    m_u[k] = s;
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_step(input string tag, input logic [N*W-1:0] cur, input bit we,
                           input logic [7:0] thr, input logic [2:0] leak, input bit sub,
                           input logic [2:0] refrac, input bit busy_poke);
        int n;
        logic [N*W-1:0] exp_st;
        logic [N-1:0]   exp_spk;
        check({tag, "_rdy"}, step_ready, 1'b1);
        current    = cur;
        step_valid = 1'b1;
        cfg_we     = we;
        cfg_thr    = thr;
        cfg_leak   = leak;
        cfg_sub    = sub;
        cfg_refrac = refrac;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        cfg_we     = 1'b0;
        if (we) begin
            m_thr = int'(thr); m_leak = int'(leak); m_sub = int'(sub); m_refrac = int'(refrac);
        end
        model_step(cur);
        check({tag, "_spkclr"}, spike, '0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && busy_poke) begin
                check({tag, "_busyrdy"}, step_ready, 1'b0);
                step_valid = 1'b1;
                cfg_we     = 1'b1;
                cfg_thr    = 8'($urandom);
                cfg_leak   = 3'($urandom);
                cfg_sub    = 1'($urandom);
                cfg_refrac = 3'($urandom);
                current    = N*W'($urandom);
            end else begin
                step_valid = 1'b0;
                cfg_we     = 1'b0;
            end
        end
        check({tag, "_lat"}, n, N + 1);
        for (int k = 0; k < N; k++) begin
            exp_st[k*W +: W] = W'(m_u[k]);
            exp_spk[k]       = 1'(m_spk[k]);
        end
        check({tag, "_spk"}, spike, exp_spk);
        check({tag, "_st"}, state, exp_st);
        @(posedge clk);
        #1;
        check({tag, "_ovpulse"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] t40 [4];
        logic [3:0] s40;
        logic [7:0] t41 [3];
        logic [7:0] t42 [3];
        logic [3:0] s43;
        int ov_cnt;
        t40 = '{8'h40, 8'h80, 8'hC0, 8'h00};
        s40 = 4'b1000;
        t41 = '{8'h30, 8'h10, 8'h40};
        t42 = '{8'h40, 8'h20, 8'h10};
        s43 = 4'b1001;

        step_valid = 1'b0; current = '0; cfg_we = 1'b0;
        cfg_thr = '0; cfg_leak = '0; cfg_sub = 1'b0; cfg_refrac = '0;
        #1;
        apply_reset();
        check("rst_ready", step_ready, 1'b1);
        check("rst_ov", out_valid, 1'b0);
        check("rst_spike", spike, '0);
        check("rst_state", state, '0);

        for (int s = 0; s < 4; s++) begin
            do_step("r040", {N{8'h40}}, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, s == 1);
            check("r040_u0", state[7:0], t40[s]);
            check("r040_s0", spike[0], s40[s]);
        end

        apply_reset();
        for (int s = 0; s < 3; s++) begin
            do_step("r041", {N{8'h30}}, s == 0, 8'h50, 3'd0, 1'b1, 3'd0, 1'b0);
            check("r041_u0", state[7:0], t41[s]);
        end

        apply_reset();
        do_step("r042_ld", {N{8'h80}}, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            do_step("r042", '0, s == 0, 8'hE6, 3'd1, 1'b0, 3'd0, 1'b0);
            check("r042_u0", state[7:0], t42[s]);
        end

        apply_reset();
        for (int s = 0; s < 4; s++) begin
            do_step("r043", {N{8'h20}}, s == 0, 8'h10, 3'd0, 1'b0, 3'd2, 1'b1);
            check("r043_s0", spike[0], s43[s]);
        end

        apply_reset();
        do_step("r045_ld", {N{8'hF0}}, 1'b1, 8'hFF, 3'd0, 1'b0, 3'd0, 1'b0);
        do_step("r045", {N{8'hFF}}, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        check("r045_s0", spike[0], 1'b1);

        // Reset during the second UPDATE cycle must abort the step.
        current = {N{8'h40}};
        step_valid = 1'b1;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("r044_st", state, '0);
        check("r044_ov", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        ov_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) ov_cnt++;
        end
        check("r044_noov", ov_cnt, 0);
        check("r044_rdy", step_ready, 1'b1);
        check("r044_st2", state, '0);

        for (int s = 0; s < 40; s++) begin
            logic [7:0] thr;
            thr = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            do_step("rand", N*W'($urandom), $urandom_range(0, 2) == 0, thr,
                    3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameter WIDTH, default 8: membrane, current and threshold width in bits.
REQ-002 Parameter N_CH, default 4: number of neuron channels; minimum 2.
REQ-003 Parameter RW, default 3: refractory counter width in bits.
REQ-004 Parameter THR_RST, default 8'hE6: threshold reset value, zero-extended or truncated to WIDTH.
REQ-005 clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 step_valid  in  1  time-step request.
REQ-008 step_ready  out  1  high only in IDLE.
REQ-009 current  in  N_CH*WIDTH  packed input currents; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 cfg_we  in  1  configuration write strobe.
REQ-011 cfg_thr  in  WIDTH  threshold value.
REQ-012 cfg_leak  in  3  leak shift amount.
REQ-013 cfg_sub  in  1  reset mode: 1 = subtract threshold, 0 = reset to zero.
REQ-014 cfg_refrac  in  RW  refractory length, in time steps.
REQ-015 out_valid  out  1  one-cycle pulse when a time step completes.
REQ-016 spike  out  N_CH  spike vector; held until the next out_valid.
REQ-017 state  out  N_CH*WIDTH  membrane potentials, packed with the same layout as current.

Function
REQ-018 FSM states SHALL be IDLE, UPDATE and DONE.
REQ-019 IDLE→UPDATE on step_valid&&step_ready; the current bus SHALL be captured into an internal register on that edge.
REQ-020 In UPDATE, one channel SHALL be processed per cycle in order 0..N_CH-1 using a channel index counter.
REQ-021 UPDATE→DONE after channel N_CH-1 is processed.
REQ-022 DONE→IDLE unconditionally; out_valid=1 in DONE only.
REQ-023 Latency SHALL be exactly N_CH+1 cycles from the accept edge to out_valid.
REQ-024 Decay: D = U − (U >> cfg_leak); cfg_leak=0 SHALL mean no leak (D=U).
REQ-025 Integration: S = D + I, computed WIDTH+1 wide and saturated to 2^WIDTH−1.
REQ-026 Refractory: if the channel's counter R>0, then I is treated as 0, no spike is generated, and R decrements by 1.
REQ-027 Spike generation: if R=0 and S ≥ threshold, the channel SHALL spike.
REQ-028 On spike with cfg_sub=1: U ← S − threshold; with cfg_sub=0: U ← 0; R ← cfg_refrac.
REQ-029 Without a spike: U ← S.
REQ-030 spike[k] and state[k] SHALL update at channel k's processing cycle; the spike register is cleared on the accept edge.
REQ-031 cfg_we SHALL be applied only in IDLE and ignored in UPDATE/DONE.
REQ-032 On simultaneous cfg_we and step accept, the configuration is written first and the new configuration governs that step.
REQ-033 Threshold 0 is legal: every non-refractory channel spikes on every step.
REQ-034 step_valid while busy SHALL be ignored; there is no queuing.

Reset
REQ-035 On rst_n low, asynchronously: FSM=IDLE, all U=0, all R=0, spike=0, out_valid=0, channel index=0, captured currents=0.
REQ-036 Reset values of configuration: threshold=THR_RST, leak=0, sub=0, refrac=0.
REQ-037 Reset asserted mid-UPDATE SHALL abort the step; no out_valid is produced.

Structure
REQ-038 A shared package lif_pkg SHALL hold the FSM state enum, the default threshold constant, and the leak field width.
REQ-039 The per-channel datapath (decay, saturating add, compare, reset-mode and refractory logic) SHALL be a combinational sub-module lif_core, instantiated once and time-multiplexed.

Verification
REQ-040 Defaults, N_CH=4, current all 8'h40, four steps: channel 0 state 40,80,C0,0 with spike on step 4 (100 saturates to FF ≥ E6, reset to zero).
REQ-041 cfg_sub=1, thr=8'h50, current 8'h30: state 30, then 60→spike→10, then 40; out_valid exactly 5 cycles after each accept.
REQ-042 cfg_leak=1, current 0, initial state 80: state 40, 20, 10 on successive steps.
REQ-043 cfg_refrac=2, thr=8'h10, current 8'h20: spike on step 1, no spike on steps 2–3, spike on step 4.
REQ-044 Assert rst_n low during UPDATE cycle 2: no out_valid, all state=0, step_ready=1 after release; cfg_we during UPDATE leaves threshold unchanged.
REQ-045 Saturation: current FF on a channel with state F0 → S=FF, spike; no wrap to a small value.
